// File: rtl/uart_loader_if.sv
// ROM write-port bundle driven by the UART program loader.
// Signals: ce_o, wen_o, addr_o[31:0], data_o[31:0]; master drives, slave (ROM) receives.
interface uart_loader_if;
  logic        ce_o;
  logic        wen_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;

  modport master (
    output ce_o,
    output wen_o,
    output addr_o,
    output data_o
  );

  modport slave (
    input ce_o,
    input wen_o,
    input addr_o,
    input data_o
  );
endinterface

// File: rtl/uart_loader.sv
// UART 8N1 program loader: packs 4 bytes little-endian into words and
// writes them to consecutive ROM word addresses while debug is high.
// Ports: clk, rst (async, active-high), debug, uart_rxd, rom (write bus),
// err_o (sticky framing error).
// Optional: define UART_LOADER_TIMEOUT_EN to drop partial words after
// TIMEOUT_BITS idle bit-times.
module uart_loader #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          debug,
  input  logic          uart_rxd,
  uart_loader_if.master rom,
  output logic          err_o
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam logic [31:0] CPB_M1  = 32'(CPB - 1);
  localparam logic [31:0] HALF_M1 = 32'(CPB / 2 - 1);

  if (CPB < 4 || TIMEOUT_BITS < 1) begin : g_bad_cfg
    $error("uart_loader: CLKS_PER_BIT must be >= 4, TIMEOUT_BITS >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_rxd_s1;
  logic        r_rxd_s2;
  logic [31:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic [1:0]  r_bcnt;
  logic        r_ce;
  logic        r_wen;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_err;
  logic        w_cnt_clr;
  logic        w_shift;
  logic        w_accept;
  logic        w_ferr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s2 <= 1'b1;
    end else begin
      r_rxd_s1 <= uart_rxd;
      r_rxd_s2 <= r_rxd_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_clr = 1'b0;
    w_shift   = 1'b0;
    w_accept  = 1'b0;
    w_ferr    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!r_rxd_s2) begin
          w_next    = S_START;
          w_cnt_clr = 1'b1;
        end
      end
      S_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_clr = 1'b1;
          // a start bit gone high by mid-bit is a glitch
          w_next    = r_rxd_s2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == CPB_M1) begin
          w_cnt_clr = 1'b1;
          w_shift   = 1'b1;
          if (r_bit == 3'd7) begin
            w_next = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (r_cnt == CPB_M1) begin
          w_cnt_clr = 1'b1;
          w_next    = S_IDLE;
          w_accept  = r_rxd_s2;
          w_ferr    = ~r_rxd_s2;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (!debug) begin
      w_next    = S_IDLE;
      w_cnt_clr = 1'b1;
      w_shift   = 1'b0;
      w_accept  = 1'b0;
      w_ferr    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      if (w_cnt_clr || r_state == S_IDLE) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (r_state == S_START) begin
        r_bit <= '0;
      end else if (w_shift) begin
        r_bit <= r_bit + 3'd1;
      end
      if (w_shift) begin
        r_shift <= {r_rxd_s2, r_shift[7:1]};
      end
    end
  end

`ifdef UART_LOADER_TIMEOUT_EN
  localparam logic [31:0] TO_M1 = 32'(TIMEOUT_BITS * CPB - 1);
  logic [31:0] r_to;
  logic        w_to_run;
  logic        w_to_expire;

  // runs only while idle with a partial word pending; a start bit clears it
  assign w_to_run    = debug && r_state == S_IDLE
                       && r_rxd_s2 && r_bcnt != 2'd0;
  assign w_to_expire = w_to_run && r_to == TO_M1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to <= '0;
    end else if (!w_to_run || w_to_expire) begin
      r_to <= '0;
    end else begin
      r_to <= r_to + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ce   <= 1'b0;
      r_wen  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
      r_bcnt <= '0;
    end else begin
      r_ce <= debug;
      if (!debug) begin
        r_wen  <= 1'b0;
        r_addr <= '0;
        r_err  <= 1'b0;
        r_bcnt <= '0;
      end else begin
        r_wen <= 1'b0;
        if (r_wen) begin
          r_addr <= r_addr + 32'd4;
        end
        if (w_ferr) begin
          r_err <= 1'b1;
        end
        if (w_accept) begin
          r_data[8*r_bcnt +: 8] <= r_shift;
          r_bcnt                <= r_bcnt + 2'd1;
          if (r_bcnt == 2'd3) begin
            r_wen <= 1'b1;
          end
        end
`ifdef UART_LOADER_TIMEOUT_EN
        else if (w_to_expire) begin
          r_bcnt <= '0;
        end
`endif
      end
    end
  end

  assign rom.ce_o   = r_ce;
  assign rom.wen_o  = r_wen;
  assign rom.addr_o = r_addr;
  assign rom.data_o = r_data;
  assign err_o      = r_err;

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader at 10 clocks per bit.
// Stimulus pushes expected writes; a negedge monitor pops on wen_o.
module tb_uart_loader;
  logic clk = 1'b0;
  logic rst;
  logic debug;
  logic uart_rxd;
  logic err_o;

  uart_loader_if bus ();

  uart_loader #(
    .CLK_FREQ    (1000),
    .BAUD        (100),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .debug   (debug),
    .uart_rxd(uart_rxd),
    .rom     (bus),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t  exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_wen = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.wen_o === 1'b1) begin
      chk("wen_single_cycle", {31'd0, prev_wen}, 32'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: addr %h data %h",
                 bus.addr_o, bus.data_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", bus.addr_o, e.a);
        chk("write_data", bus.data_o, e.d);
      end
    end
    prev_wen = bus.wen_o;
  end

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (10) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (10) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send4(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], 1'b1);
    end
  endtask

  task automatic restart();
    @(negedge clk);
    debug = 1'b0;
    repeat (2) @(negedge clk);
    chk("addr_cleared", bus.addr_o, 32'h0);
    chk("err_cleared", {31'd0, err_o}, 32'd0);
    debug = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    debug    = 1'b0;
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ce", {31'd0, bus.ce_o}, 32'd0);
    chk("rst_wen", {31'd0, bus.wen_o}, 32'd0);
    chk("rst_addr", bus.addr_o, 32'h0);
    chk("rst_data", bus.data_o, 32'h0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    rst = 1'b0;
    debug = 1'b1;
    repeat (2) @(negedge clk);
    chk("ce_follows_debug", {31'd0, bus.ce_o}, 32'd1);

    push(32'h0, 32'h0010_0513);
    send4(32'h0010_0513);
    chk("addr_after_word", bus.addr_o, 32'h4);

    restart();
    push(32'h0, 32'h0403_0201);
    push(32'h4, 32'h0807_0605);
    send4(32'h0403_0201);
    send4(32'h0807_0605);
    chk("err_after_8", {31'd0, err_o}, 32'd0);
    chk("addr_after_8", bus.addr_o, 32'h8);

    restart();
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_no_err", {31'd0, err_o}, 32'd0);
    chk("glitch_no_addr", bus.addr_o, 32'h0);
    push(32'h0, 32'hD4C3_B2A1);
    send4(32'hD4C3_B2A1);
    chk("addr_after_glitch", bus.addr_o, 32'h4);

    restart();
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'h55, 1'b0);
    chk("ferr_set", {31'd0, err_o}, 32'd1);
    push(32'h0, 32'hDDCC_BBAA);
    send_byte(8'hCC, 1'b1);
    send_byte(8'hDD, 1'b1);
    chk("ferr_sticky", {31'd0, err_o}, 32'd1);
    chk("addr_after_ferr", bus.addr_o, 32'h4);
    @(negedge clk);
    debug = 1'b0;
    repeat (2) @(negedge clk);
    chk("debug_low_err", {31'd0, err_o}, 32'd0);
    chk("debug_low_addr", bus.addr_o, 32'h0);
    chk("debug_low_data", bus.data_o, 32'hDDCC_BBAA);
    chk("debug_low_ce", {31'd0, bus.ce_o}, 32'd0);
    debug = 1'b1;
    repeat (2) @(negedge clk);

    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    debug = 1'b0;
    @(negedge clk);
    debug = 1'b1;
    repeat (2) @(negedge clk);
    push(32'h0, 32'h4433_2211);
    send4(32'h4433_2211);
    chk("addr_after_partial", bus.addr_o, 32'h4);

    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ce", {31'd0, bus.ce_o}, 32'd0);
    chk("midrst_wen", {31'd0, bus.wen_o}, 32'd0);
    chk("midrst_addr", bus.addr_o, 32'h0);
    chk("midrst_data", bus.data_o, 32'h0);
    chk("midrst_err", {31'd0, err_o}, 32'd0);
    uart_rxd = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    send_byte(8'hE1, 1'b1);
    send_byte(8'hE2, 1'b1);
    send_byte(8'hE3, 1'b1);
    repeat (230) @(negedge clk);
`ifdef UART_LOADER_TIMEOUT_EN
    push(32'h0, 32'h4433_2211);
`else
    push(32'h0, 32'h11E3_E2E1);
`endif
    send4(32'h4433_2211);
    chk("addr_after_idle", bus.addr_o, 32'h4);
    chk("err_after_idle", {31'd0, err_o}, 32'd0);

    repeat (50) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
